// File: rtl/mcu_cmd_responder.sv
// Memory-control-unit command responder: accepts one vector load/store, streams element addresses,
// and tracks load responses until the buffer is full. Optional alignment check: MCU_ALIGN_CHECK_EN.
module mcu_cmd_responder #(
  parameter int unsigned VL_W            = 12,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mcu_ld_vld_i,
  output logic            mcu_ld_rdy_o,
  output logic            mcu_ld_buffered_o,
  input  logic            mcu_st_vld_i,
  output logic            mcu_st_rdy_o,
  input  logic [31:0]     mcu_base_addr_i,
  input  logic [31:0]     mcu_stride_i,
  input  logic [2:0]      mcu_data_width_i,
  input  logic            mcu_unit_ld_st_i,
  input  logic            mcu_strided_ld_st_i,
  input  logic            mcu_idx_ld_st_i,
  input  logic [VL_W-1:0] vl_i,
  output logic            rd_req_vld_o,
  input  logic            rd_req_rdy_i,
  output logic [31:0]     rd_req_addr_o,
  input  logic            rd_resp_vld_i,
  output logic            wr_req_vld_o,
  input  logic            wr_req_rdy_i,
  output logic [31:0]     wr_req_addr_o,
  input  logic            ld_consumed_i,
  output logic            misalign_err_o
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ESZ_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_WAIT,
    LD_BUFFERED,
    ST_ISSUE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [VL_W-1:0]   issued_q, issued_d;
  logic [VL_W-1:0]   returned_q, returned_d;
  logic              buffered_q, buffered_d;

  logic              ld_accept, st_accept;
  logic              rd_hs, wr_hs, resp_ok;
  logic [VL_W-1:0]   outstanding;
  logic [ESZ_W-1:0]  cmd_esize;
  logic [ADDR_W-1:0] cmd_step;
  logic              cmd_noop;

  // Element size in bytes from the vector width field; unlisted codes fall back to 4
  always_comb begin
    cmd_esize = ESZ_W'(4);
    case (mcu_data_width_i)
      3'b000:  cmd_esize = ESZ_W'(1);
      3'b101:  cmd_esize = ESZ_W'(2);
      default: cmd_esize = ESZ_W'(4);
    endcase
  end

  assign cmd_step = (mcu_strided_ld_st_i && !mcu_unit_ld_st_i) ? mcu_stride_i
                                                                : ADDR_W'(cmd_esize);
  assign cmd_noop = (vl_i == '0) || mcu_idx_ld_st_i;

  assign ld_accept = (state_q == IDLE) && mcu_ld_vld_i;
  assign st_accept = (state_q == IDLE) && mcu_st_vld_i && !mcu_ld_vld_i;

  // Ready is gated by reset so every output reads 0 while reset is held
  assign mcu_ld_rdy_o = (state_q == IDLE) && !rst;
  assign mcu_st_rdy_o = (state_q == IDLE) && !rst;

  assign outstanding  = issued_q - returned_q;
  assign rd_req_vld_o = (state_q == LD_ISSUE) && (issued_q < vl_q) &&
                        (outstanding < VL_W'(MAX_OUTSTANDING));
  assign wr_req_vld_o = (state_q == ST_ISSUE);
  assign rd_req_addr_o = addr_q;
  assign wr_req_addr_o = addr_q;
  assign mcu_ld_buffered_o = buffered_q;

  assign rd_hs   = rd_req_vld_o && rd_req_rdy_i;
  assign wr_hs   = wr_req_vld_o && wr_req_rdy_i;
  assign resp_ok = rd_resp_vld_i && (returned_q != vl_q) &&
                   ((state_q == LD_ISSUE) || (state_q == LD_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      step_q     <= '0;
      vl_q       <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      buffered_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      step_q     <= step_d;
      vl_q       <= vl_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      buffered_q <= buffered_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    step_d     = step_q;
    vl_d       = vl_q;
    issued_d   = issued_q + VL_W'(rd_hs || wr_hs);
    returned_d = returned_q + VL_W'(resp_ok);

    case (state_q)
      IDLE: begin
        if (ld_accept || st_accept) begin
          addr_d     = mcu_base_addr_i;
          step_d     = cmd_step;
          vl_d       = vl_i;
          issued_d   = '0;
          returned_d = '0;
          if (ld_accept) begin
            state_d = cmd_noop ? LD_BUFFERED : LD_ISSUE;
          end else begin
            state_d = cmd_noop ? IDLE : ST_ISSUE;
          end
        end
      end
      LD_ISSUE: begin
        if (rd_hs) begin
          addr_d = addr_q + step_q;
        end
        if (issued_d == vl_q) begin
          state_d = (returned_d == vl_q) ? LD_BUFFERED : LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (returned_d == vl_q) begin
          state_d = LD_BUFFERED;
        end
      end
      LD_BUFFERED: begin
        if (ld_consumed_i) begin
          state_d = IDLE;
        end
      end
      ST_ISSUE: begin
        if (wr_hs) begin
          addr_d = addr_q + step_q;
        end
        if (issued_d == vl_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    buffered_d = (state_d == LD_BUFFERED);
  end

`ifdef MCU_ALIGN_CHECK_EN
  logic [ESZ_W-1:0]  esize_q;
  logic              misalign_q;
  logic [ADDR_W-1:0] align_mask;

  assign align_mask = ADDR_W'(esize_q) - ADDR_W'(1);

  // Sticky flag: set by any misaligned issued address, cleared by the next acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esize_q    <= ESZ_W'(1);
      misalign_q <= 1'b0;
    end else if (ld_accept || st_accept) begin
      esize_q    <= cmd_esize;
      misalign_q <= 1'b0;
    end else if ((rd_hs || wr_hs) && ((addr_q & align_mask) != '0)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err_o = misalign_q;
`else
  assign misalign_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_cmd_responder.sv
// Self-checking bench for mcu_cmd_responder: directed table, hand-written corner sequences,
// and randomized commands checked against an address/count model.
module tb_mcu_cmd_responder;
  localparam int unsigned VL_W    = 12;
  localparam int unsigned MAX_OUT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            mcu_ld_vld_i, mcu_ld_rdy_o, mcu_ld_buffered_o;
  logic            mcu_st_vld_i, mcu_st_rdy_o;
  logic [31:0]     mcu_base_addr_i, mcu_stride_i;
  logic [2:0]      mcu_data_width_i;
  logic            mcu_unit_ld_st_i, mcu_strided_ld_st_i, mcu_idx_ld_st_i;
  logic [VL_W-1:0] vl_i;
  logic            rd_req_vld_o, rd_req_rdy_i, rd_resp_vld_i;
  logic [31:0]     rd_req_addr_o, wr_req_addr_o;
  logic            wr_req_vld_o, wr_req_rdy_i;
  logic            ld_consumed_i, misalign_err_o;

  always #5 clk = ~clk;

  mcu_cmd_responder #(.VL_W(VL_W), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .mcu_ld_vld_i(mcu_ld_vld_i), .mcu_ld_rdy_o(mcu_ld_rdy_o),
    .mcu_ld_buffered_o(mcu_ld_buffered_o),
    .mcu_st_vld_i(mcu_st_vld_i), .mcu_st_rdy_o(mcu_st_rdy_o),
    .mcu_base_addr_i(mcu_base_addr_i), .mcu_stride_i(mcu_stride_i),
    .mcu_data_width_i(mcu_data_width_i), .mcu_unit_ld_st_i(mcu_unit_ld_st_i),
    .mcu_strided_ld_st_i(mcu_strided_ld_st_i), .mcu_idx_ld_st_i(mcu_idx_ld_st_i),
    .vl_i(vl_i),
    .rd_req_vld_o(rd_req_vld_o), .rd_req_rdy_i(rd_req_rdy_i), .rd_req_addr_o(rd_req_addr_o),
    .rd_resp_vld_i(rd_resp_vld_i),
    .wr_req_vld_o(wr_req_vld_o), .wr_req_rdy_i(wr_req_rdy_i), .wr_req_addr_o(wr_req_addr_o),
    .ld_consumed_i(ld_consumed_i), .misalign_err_o(misalign_err_o)
  );

  // mode: 0 unit, 1 strided, 2 indexed, 3 no mode bit set
  typedef struct {
    bit          ld;
    logic [31:0] base;
    logic [31:0] stride;
    logic [2:0]  w;
    logic [1:0]  mode;
    int          vl;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] esize_of(input logic [2:0] w);
    if (w == 3'b000) return 32'd1;
    if (w == 3'b101) return 32'd2;
    return 32'd4;
  endfunction

  task automatic drive_cmd(input logic [31:0] base, stride, input logic [2:0] w,
                           input logic [1:0] mode, input int vl);
    mcu_base_addr_i     = base;
    mcu_stride_i        = stride;
    mcu_data_width_i    = w;
    mcu_unit_ld_st_i    = (mode == 2'd0);
    mcu_strided_ld_st_i = (mode == 2'd1);
    mcu_idx_ld_st_i     = (mode == 2'd2);
    vl_i                = VL_W'(vl);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ld_rdy"}, mcu_ld_rdy_o, 0);
    chk({tag, "_st_rdy"}, mcu_st_rdy_o, 0);
    chk({tag, "_buffered"}, mcu_ld_buffered_o, 0);
    chk({tag, "_rd_vld"}, rd_req_vld_o, 0);
    chk({tag, "_wr_vld"}, wr_req_vld_o, 0);
    chk({tag, "_rd_addr"}, rd_req_addr_o, 0);
    chk({tag, "_wr_addr"}, wr_req_addr_o, 0);
    chk({tag, "_misalign"}, misalign_err_o, 0);
  endtask

  // Runs one command end to end against the model; returns observed handshake count and addresses
  task automatic run_cmd(input bit ld, input logic [31:0] base, stride, input logic [2:0] w,
                         input logic [1:0] mode, input int vl, input int rdy_pct,
                         input int resp_pct, output int n, output logic [31:0] first, last);
    logic [31:0] step, esz, exp_addr;
    bit noop, mis, vld_now, r, p;
    int iss, ret, cyc;
    esz  = esize_of(w);
    step = (mode == 2'd1) ? stride : esz;
    noop = (vl == 0) || (mode == 2'd2);
    n = 0; first = '0; last = '0; iss = 0; ret = 0; mis = 0; cyc = 0;
    chk(ld ? "ld_rdy" : "st_rdy", ld ? mcu_ld_rdy_o : mcu_st_rdy_o, 1);
    drive_cmd(base, stride, w, mode, vl);
    mcu_ld_vld_i = ld;
    mcu_st_vld_i = !ld;
    tick();
    mcu_ld_vld_i = 1'b0;
    mcu_st_vld_i = 1'b0;
    if (!ld) begin
      while (!noop && iss < vl && cyc < 2000) begin
        chk("wr_vld", wr_req_vld_o, 1);
        exp_addr = base + 32'(iss) * step;
        chk("wr_addr", wr_req_addr_o, exp_addr);
        r = ($urandom_range(99) < rdy_pct);
        wr_req_rdy_i = r;
        if (r) begin
          if (n == 0) first = wr_req_addr_o;
          last = wr_req_addr_o;
          n++;
          if ((exp_addr % esz) != 0) mis = 1'b1;
          iss++;
        end
        tick();
        cyc++;
      end
      wr_req_rdy_i = 1'b0;
      if (cyc >= 2000) timeout("st_budget");
      chk("st_done_wr_vld", wr_req_vld_o, 0);
      chk("st_done_rdy", mcu_st_rdy_o, 1);
    end else if (noop) begin
      chk("noop_rd_vld0", rd_req_vld_o, 0);
      tick();
      chk("noop_rd_vld1", rd_req_vld_o, 0);
      chk("noop_buffered", mcu_ld_buffered_o, 1);
    end else begin
      while (ret < vl && cyc < 2000) begin
        vld_now = (iss < vl) && ((iss - ret) < MAX_OUT);
        chk("rd_vld", rd_req_vld_o, vld_now);
        chk("buffered_busy", mcu_ld_buffered_o, 0);
        p = (ret < iss) && ($urandom_range(99) < resp_pct);
        r = vld_now && ($urandom_range(99) < rdy_pct);
        rd_req_rdy_i  = r;
        rd_resp_vld_i = p;
        if (r) begin
          exp_addr = base + 32'(iss) * step;
          chk("rd_addr", rd_req_addr_o, exp_addr);
          if (n == 0) first = rd_req_addr_o;
          last = rd_req_addr_o;
          n++;
          if ((exp_addr % esz) != 0) mis = 1'b1;
          iss++;
        end
        if (p) ret++;
        tick();
        cyc++;
      end
      rd_req_rdy_i  = 1'b0;
      rd_resp_vld_i = 1'b0;
      if (cyc >= 2000) timeout("ld_budget");
      chk("ld_done_rd_vld", rd_req_vld_o, 0);
      chk("buffered_set", mcu_ld_buffered_o, 1);
    end
    if (ld) begin
      repeat ($urandom_range(2)) tick();
      chk("buffered_hold", mcu_ld_buffered_o, 1);
      ld_consumed_i = 1'b1;
      tick();
      ld_consumed_i = 1'b0;
      chk("buffered_clear", mcu_ld_buffered_o, 0);
      chk("ld_rdy_after", mcu_ld_rdy_o, 1);
    end
`ifdef MCU_ALIGN_CHECK_EN
    chk("misalign", misalign_err_o, 32'(mis));
`else
    chk("misalign", misalign_err_o, 0);
`endif
  endtask

  vec_t tbl[9];

  initial begin
    int          n, cnt;
    logic [31:0] f, l;
    tbl[0] = '{1'b1, 32'h0000_1000, 32'h0,         3'b110, 2'd0, 4, 4, 32'h0000_1000, 32'h0000_100C};
    tbl[1] = '{1'b0, 32'h0000_2000, 32'hFFFF_FFF0, 3'b000, 2'd1, 3, 3, 32'h0000_2000, 32'h0000_1FE0};
    tbl[2] = '{1'b1, 32'h0000_4000, 32'h0,         3'b110, 2'd0, 0, 0, 32'h0,         32'h0};
    tbl[3] = '{1'b1, 32'h0000_4000, 32'h0,         3'b110, 2'd2, 5, 0, 32'h0,         32'h0};
    tbl[4] = '{1'b0, 32'h0000_4000, 32'h0,         3'b000, 2'd2, 3, 0, 32'h0,         32'h0};
    tbl[5] = '{1'b1, 32'h0000_1002, 32'h0,         3'b110, 2'd0, 1, 1, 32'h0000_1002, 32'h0000_1002};
    tbl[6] = '{1'b1, 32'h0000_0010, 32'h0,         3'b101, 2'd3, 3, 3, 32'h0000_0010, 32'h0000_0014};
    tbl[7] = '{1'b0, 32'h0000_0000, 32'h0,         3'b011, 2'd0, 2, 2, 32'h0000_0000, 32'h0000_0004};
    tbl[8] = '{1'b1, 32'hFFFF_FF00, 32'h0000_0100, 3'b000, 2'd1, 3, 3, 32'hFFFF_FF00, 32'h0000_0100};

    rst = 1'b1;
    mcu_ld_vld_i = 1'b0; mcu_st_vld_i = 1'b0;
    rd_req_rdy_i = 1'b0; rd_resp_vld_i = 1'b0; wr_req_rdy_i = 1'b0; ld_consumed_i = 1'b0;
    drive_cmd(32'h0, 32'h0, 3'b000, 2'd0, 0);
    #12;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("post_reset_ld_rdy", mcu_ld_rdy_o, 1);
    chk("post_reset_st_rdy", mcu_st_rdy_o, 1);

    foreach (tbl[i]) begin
      run_cmd(tbl[i].ld, tbl[i].base, tbl[i].stride, tbl[i].w, tbl[i].mode, tbl[i].vl,
              100, 100, n, f, l);
      chk($sformatf("tbl%0d_count", i), 32'(n), 32'(tbl[i].exp_n));
      if (tbl[i].exp_n > 0) begin
        chk($sformatf("tbl%0d_first", i), f, tbl[i].exp_first);
        chk($sformatf("tbl%0d_last", i), l, tbl[i].exp_last);
      end
    end

    // Simultaneous load and store: load wins, store is held off
    drive_cmd(32'h0, 32'h0, 3'b110, 2'd0, 0);
    mcu_ld_vld_i = 1'b1; mcu_st_vld_i = 1'b1;
    tick();
    mcu_ld_vld_i = 1'b0; mcu_st_vld_i = 1'b0;
    chk("both_st_rdy", mcu_st_rdy_o, 0);
    chk("both_ld_rdy", mcu_ld_rdy_o, 0);
    tick();
    chk("both_buffered", mcu_ld_buffered_o, 1);
    ld_consumed_i = 1'b1;
    tick();
    ld_consumed_i = 1'b0;
    chk("both_buffered_clr", mcu_ld_buffered_o, 0);

    // Outstanding cap with no responses, then one response admits one request
    drive_cmd(32'h3000, 32'h0, 3'b110, 2'd0, 5);
    mcu_ld_vld_i = 1'b1;
    tick();
    mcu_ld_vld_i = 1'b0;
    rd_req_rdy_i = 1'b1;
    cnt = 0;
    repeat (6) begin
      if (rd_req_vld_o) cnt++;
      tick();
    end
    chk("cap_count", 32'(cnt), 32'(MAX_OUT));
    chk("cap_vld_low", rd_req_vld_o, 0);
    rd_resp_vld_i = 1'b1;
    tick();
    rd_resp_vld_i = 1'b0;
    cnt = 0;
    repeat (4) begin
      if (rd_req_vld_o) cnt++;
      tick();
    end
    chk("cap_one_more", 32'(cnt), 1);

    // Reset aborts mid-issue: vl=8 after two requests
    #2 rst = 1'b1;
    #1 chk_all_zero("abort1");
    tick();
    rst = 1'b0;
    tick();
    drive_cmd(32'h5000, 32'h0, 3'b110, 2'd0, 8);
    mcu_ld_vld_i = 1'b1;
    tick();
    mcu_ld_vld_i = 1'b0;
    rd_req_rdy_i = 1'b1;
    cnt = 0;
    repeat (2) begin
      if (rd_req_vld_o) cnt++;
      tick();
    end
    chk("abort_issued", 32'(cnt), 2);
    #2 rst = 1'b1;
    #1 chk_all_zero("abort2");
    rd_req_rdy_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("abort_ld_rdy", mcu_ld_rdy_o, 1);
    rd_resp_vld_i = 1'b1;
    repeat (3) begin
      tick();
      chk("stray_rd_vld", rd_req_vld_o, 0);
      chk("stray_buffered", mcu_ld_buffered_o, 0);
      chk("stray_ld_rdy", mcu_ld_rdy_o, 1);
    end
    rd_resp_vld_i = 1'b0;
    run_cmd(1'b1, 32'h6000, 32'h0, 3'b110, 2'd0, 2, 100, 100, n, f, l);
    chk("post_abort_count", 32'(n), 2);

    // Randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      bit          rld;
      logic [1:0]  rmode;
      logic [2:0]  rw;
      logic [31:0] rbase;
      int          s, rvl;
      rld   = 1'($urandom_range(1));
      rmode = 2'($urandom_range(3));
      rw    = 3'($urandom_range(7));
      rbase = $urandom;
      if ($urandom_range(3) != 0) rbase = rbase & 32'hFFFF_FFFC;
      s     = int'($urandom_range(64)) - 32;
      rvl   = int'($urandom_range(10));
      run_cmd(rld, rbase, 32'(s), rw, rmode, rvl, int'($urandom_range(100, 30)),
              int'($urandom_range(100, 30)), n, f, l);
      chk("rand_count", 32'(n), (rvl == 0 || rmode == 2'd2) ? 32'd0 : 32'(rvl));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mcu_cmd_responder.md
Name: mcu_cmd_responder

Overview:
- Memory-control-unit front end that answers the vector scheduler's load/store handshakes.
- Accepts one load or store command with its base, stride and width, then generates the element address stream toward the memory port.
- For loads, counts read responses and asserts mcu_ld_buffered_o once all vl elements are buffered; holds it until V_CU drains the buffer.

Parameters:
- VL_W, 12: width of the vector-length (element count) input.
- MAX_OUTSTANDING, 4: maximum accepted read requests without a response; 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mcu_ld_vld_i  in  1  load command valid from scheduler
- mcu_ld_rdy_o  out  1  load command ready
- mcu_ld_buffered_o  out  1  all load elements buffered (level)
- mcu_st_vld_i  in  1  store command valid
- mcu_st_rdy_o  out  1  store command ready
- mcu_base_addr_i  in  32  base address
- mcu_stride_i  in  32  byte stride (strided mode)
- mcu_data_width_i  in  3  element width code (vector ld/st width field)
- mcu_unit_ld_st_i  in  1  unit-stride mode
- mcu_strided_ld_st_i  in  1  strided mode
- mcu_idx_ld_st_i  in  1  indexed mode
- vl_i  in  VL_W  element count, sampled at acceptance
- rd_req_vld_o  out  1  memory read request valid
- rd_req_rdy_i  in  1  memory read request ready
- rd_req_addr_o  out  32  read address
- rd_resp_vld_i  in  1  one read element returned into load buffer
- wr_req_vld_o  out  1  memory write request valid
- wr_req_rdy_i  in  1  memory write request ready
- wr_req_addr_o  out  32  write address
- ld_consumed_i  in  1  V_CU has drained the load buffer
- misalign_err_o  out  1  sticky misaligned-address flag (see Optional Feature)

Behaviour:
- Reset: state IDLE; all counters 0; address register 0; every output 0.
- mcu_ld_rdy_o and mcu_st_rdy_o are 1 only in IDLE, combinationally.
- Acceptance: vld&&rdy in IDLE; load has priority if both valid (store stays pending).
- At acceptance, the block samples base, stride, mode, width and vl. It sets addr=base and issued=returned=0.
- Element size from width code: 000→1, 101→2, 110→4; any other code→4.
- Step: unit mode→element size; strided mode→mcu_stride_i; if no mode bit is set, unit mode applies.
- Address arithmetic is 32-bit modulo 2^32. Stride is signed two's complement, so a negative stride wraps downward.
- States:
  - IDLE
    - Load accept: →LD_ISSUE; →LD_BUFFERED if vl=0 or indexed.
    - Store accept: →ST_ISSUE; →IDLE if vl=0 or indexed (store is a no-op).
  - LD_ISSUE
    - rd_req_vld_o=1 while issued<vl and (issued−returned)<MAX_OUTSTANDING.
    - Each rd handshake: addr+=step, issued++.
    - When issued==vl: →LD_WAIT.
    - First request is valid the cycle after acceptance.
  - LD_WAIT
    - No requests; returned increments on rd_resp_vld_i.
    - When returned==vl: →LD_BUFFERED.
    - Responses arriving during LD_ISSUE are also counted.
    - A response and a request in the same cycle update both counters.
  - LD_BUFFERED
    - mcu_ld_buffered_o=1; ignores all vld inputs.
    - On ld_consumed_i: →IDLE; buffered_o deasserts the next cycle.
  - ST_ISSUE
    - wr_req_vld_o=1 until vl handshakes complete (addr+=step each handshake), then →IDLE.
- Requests hold valid and address stable until ready.
- Excess rd_resp_vld_i pulses (returned==vl, or outside LD_ISSUE/LD_WAIT) are ignored.
- ld_consumed_i outside LD_BUFFERED is ignored.
- Reset asserted mid-operation aborts immediately to the reset state; in-flight responses after reset release are ignored (state IDLE).

Optional Feature:
- Macro: MCU_ALIGN_CHECK_EN.
- Defined:
  - misalign_err_o sets (registered, one cycle after the handshake) when an issued rd/wr address is not a multiple of the element size.
  - It stays set until the next command acceptance, which clears it.
  - Requests still issue.
- Undefined: misalign_err_o is tied to 0 and no check logic is built.

Test Plan:
- Unit load: base=0x1000, width=110, vl=4, rd_req_rdy=1, one response per cycle → addrs 0x1000/4/8/C on consecutive cycles. buffered_o rises after the 4th response; falls one cycle after ld_consumed_i.
- Strided store: base=0x2000, stride=0xFFFFFFF0, vl=3, width=000 → wr addrs 0x2000, 0x1FF0, 0x1FE0, then IDLE with st_rdy_o=1.
- Outstanding limit: MAX_OUTSTANDING=2, vl=5, no responses → exactly 2 read requests, then rd_req_vld_o=0. One response admits exactly one more request.
- vl=0 load and indexed load → no rd requests; buffered_o=1 two cycles after acceptance. Simultaneous ld/st valid → load accepted, st_rdy_o=0.
- Reset mid-LD_ISSUE after 2 of 8 requests → all outputs 0 asynchronously; after release, ld_rdy_o=1 and stray responses are ignored.
- With MCU_ALIGN_CHECK_EN: base=0x1002, width=110, vl=1 → misalign_err_o=1 after the request; cleared on the next acceptance.
